shifter_operand: RTL and testbench

- Sequential front end for the combinational `shift` unit in the ARMv4 execute stage.
- Decodes the data-processing operand2 field (immediate rotate, immediate shift, register shift).
- Fetches Rs for register-specified shifts and applies ARM special-case amount rules.
- Delivers {shifter_operand, shifter_carry_out} to the ALU over a valid/ready handshake.

---
 rtl/shift_pkg.sv | 39 +++
 rtl/shift.sv | 55 +++++
 rtl/shifter_operand.sv | 216 +++++++++++++++++++++
 tb/tb_shifter_operand.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/shift_pkg.sv
`default_nettype none
// ============================================================================
// Module      : shift_pkg
// Description : Shared definitions for the ARMv4 shifter-operand front end:
//               shift type encodings, front-end FSM states and the bit
//               positions of the fields inside the 12-bit operand2 field.
// Revision    : 1.0 - initial release
// ============================================================================
package shift_pkg;

  // Encoding of operand2[6:5]
  typedef enum logic [1:0] {
    SH_LSL = 2'b00,
    SH_LSR = 2'b01,
    SH_ASR = 2'b10,
    SH_ROR = 2'b11
  } shift_type_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_RS_WAIT = 2'b01,
    ST_OUT     = 2'b10
  } state_e;

  // operand2 field positions
  localparam int OP2_ROT_MSB   = 11;  // immediate rotate (x2)
  localparam int OP2_ROT_LSB   = 8;
  localparam int OP2_IMM8_MSB  = 7;   // 8-bit immediate
  localparam int OP2_IMM8_LSB  = 0;
  localparam int OP2_SHAMT_MSB = 11;  // 5-bit immediate shift amount
  localparam int OP2_SHAMT_LSB = 7;
  localparam int OP2_TYPE_MSB  = 6;   // shift type
  localparam int OP2_TYPE_LSB  = 5;
  localparam int OP2_REGSH_BIT = 4;   // 1 = shift amount comes from Rs
  localparam int OP2_RS_MSB    = 11;  // Rs register index
  localparam int OP2_RS_LSB    = 8;

endpackage : shift_pkg
`default_nettype wire

// File: rtl/shift.sv
`default_nettype none
// ============================================================================
// Module      : shift
// Description : Combinational barrel shifter for one fixed shift type.
//               Amount 0 passes the operand and the incoming carry through;
//               amounts 1..DATA_WIDTH-1 shift normally and return the last
//               bit shifted out as carry.
// Ports       : i_op     - operand
//               i_amount - shift amount
//               i_carry  - carry returned when the amount is 0
//               o_result - shifted operand
//               o_carry  - shifter carry out
// Revision    : 1.0 - initial release
// ============================================================================
module shift
  import shift_pkg::*;
#(
  parameter int          DATA_WIDTH = 32,
  parameter shift_type_e SHIFT_TYPE = SH_LSL
) (
  input  logic [DATA_WIDTH-1:0]         i_op,
  input  logic [$clog2(DATA_WIDTH)-1:0] i_amount,
  input  logic                          i_carry,
  output logic [DATA_WIDTH-1:0]         o_result,
  output logic                          o_carry
);

  logic w_zero;
  assign w_zero = (i_amount == '0);

  if (SHIFT_TYPE == SH_LSL) begin : g_lsl
    // Extra MSB catches the last bit shifted out of the top
    logic [DATA_WIDTH:0] w_ext;
    assign w_ext    = {1'b0, i_op} << i_amount;
    assign o_result = w_ext[DATA_WIDTH-1:0];
    assign o_carry  = w_zero ? i_carry : w_ext[DATA_WIDTH];
  end else if (SHIFT_TYPE == SH_LSR) begin : g_lsr
    // Extra LSB catches the last bit shifted out of the bottom
    logic [DATA_WIDTH:0] w_ext;
    assign w_ext    = {i_op, 1'b0} >> i_amount;
    assign o_result = w_ext[DATA_WIDTH:1];
    assign o_carry  = w_zero ? i_carry : w_ext[0];
  end else if (SHIFT_TYPE == SH_ASR) begin : g_asr
    logic signed [DATA_WIDTH:0] w_ext;
    assign w_ext    = $signed({i_op, 1'b0}) >>> i_amount;
    assign o_result = w_ext[DATA_WIDTH:1];
    assign o_carry  = w_zero ? i_carry : w_ext[0];
  end else begin : g_ror
    // A shift by DATA_WIDTH yields 0, so amount 0 degenerates to i_op
    assign o_result = (i_op >> i_amount) | (i_op << (DATA_WIDTH - int'(i_amount)));
    assign o_carry  = w_zero ? i_carry : o_result[DATA_WIDTH-1];
  end

endmodule : shift
`default_nettype wire

// File: rtl/shifter_operand.sv
`default_nettype none
// ============================================================================
// Module      : shifter_operand
// Description : Sequential front end of the ARMv4 data-processing shifter.
//               Decodes operand2 (rotated immediate, immediate shift or
//               register shift), fetches Rs when needed, applies the ARM
//               special-case amount rules and returns {result, carry} over a
//               valid/ready handshake.
// Ports       : i_clk, i_rst_n          - clock, async active-low reset
//               i_valid/o_ready         - request handshake
//               i_imm, i_operand2       - instruction bit 25 and bits [11:0]
//               i_rm_data, i_carry      - Rm value and CPSR C flag
//               o_rs_req, o_rs_addr     - Rs read strobe and index
//               i_rs_data               - Rs value, one cycle after o_rs_req
//               o_valid/i_ready         - result handshake
//               o_result, o_carry       - shifter operand and carry out
// Revision    : 1.0 - initial release
// ============================================================================
module shifter_operand
  import shift_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic                  i_imm,
  input  logic [11:0]           i_operand2,
  input  logic [DATA_WIDTH-1:0] i_rm_data,
  input  logic                  i_carry,
  output logic                  o_rs_req,
  output logic [3:0]            o_rs_addr,
  input  logic [DATA_WIDTH-1:0] i_rs_data,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [DATA_WIDTH-1:0] o_result,
  output logic                  o_carry
);

  localparam int AW = $clog2(DATA_WIDTH);

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] rm_q;
  logic                  c_q;
  shift_type_e           type_q;
  logic [3:0]            rs_addr_q;
  logic [DATA_WIDTH-1:0] result_q, result_d;
  logic                  carry_q, carry_d;

  logic                  w_accept;
  logic                  w_in_regsh;
  logic                  w_sel_rs;
  logic                  w_imm_form;
  logic                  w_load;
  logic [DATA_WIDTH-1:0] w_src_rm;
  logic                  w_src_c;
  shift_type_e           w_type;
  logic [7:0]            w_amt8;
  logic [DATA_WIDTH-1:0] w_sh_op;
  logic [AW-1:0]         w_sh_amt;
  logic [DATA_WIDTH-1:0] w_sh_res [4];
  logic                  w_sh_c   [4];
  logic                  w_unused_rs;

  // Only the low byte of Rs is a shift amount
  assign w_unused_rs = ^i_rs_data[DATA_WIDTH-1:8];

  assign w_accept   = i_valid && o_ready;
  assign w_in_regsh = !i_imm && i_operand2[OP2_REGSH_BIT];

  // In RS_WAIT the datapath works on captured operands plus the arriving Rs;
  // in every other state it works directly on the request being accepted.
  assign w_sel_rs   = (state_q == ST_RS_WAIT);
  assign w_imm_form = !w_sel_rs && i_imm;
  assign w_src_rm   = w_sel_rs ? rm_q : i_rm_data;
  assign w_src_c    = w_sel_rs ? c_q  : i_carry;
  assign w_type     = w_sel_rs ? type_q
                               : shift_type_e'(i_operand2[OP2_TYPE_MSB:OP2_TYPE_LSB]);
  assign w_amt8     = w_sel_rs ? i_rs_data[7:0]
                               : 8'(i_operand2[OP2_SHAMT_MSB:OP2_SHAMT_LSB]);

  // Rotated immediate reuses the ROR unit: imm8 rotated by 2*rot
  assign w_sh_op  = w_imm_form ? DATA_WIDTH'(i_operand2[OP2_IMM8_MSB:OP2_IMM8_LSB]) : w_src_rm;
  assign w_sh_amt = w_imm_form ? AW'({i_operand2[OP2_ROT_MSB:OP2_ROT_LSB], 1'b0})
                               : w_amt8[AW-1:0];

  for (genvar t = 0; t < 4; t++) begin : g_shift
    shift #(
      .DATA_WIDTH (DATA_WIDTH),
      .SHIFT_TYPE (shift_type_e'(2'(t)))
    ) u_shift (
      .i_op     (w_sh_op),
      .i_amount (w_sh_amt),
      .i_carry  (w_src_c),
      .o_result (w_sh_res[t]),
      .o_carry  (w_sh_c[t])
    );
  end

  // Amount-zero and amount>=32 special cases layered over the 1..31 units
  always_comb begin
    result_d = w_sh_res[w_type];
    carry_d  = w_sh_c[w_type];
    if (w_imm_form) begin
      result_d = w_sh_res[SH_ROR];
      carry_d  = w_sh_c[SH_ROR];
    end else if (!w_sel_rs) begin
      // Immediate shift: #0 encodes #32 for LSR/ASR and RRX for ROR
      if (w_amt8[AW-1:0] == '0) begin
        case (w_type)
          SH_LSL: begin result_d = w_src_rm;                         carry_d = w_src_c; end
          SH_LSR: begin result_d = '0;                               carry_d = w_src_rm[DATA_WIDTH-1]; end
          SH_ASR: begin result_d = {DATA_WIDTH{w_src_rm[DATA_WIDTH-1]}}; carry_d = w_src_rm[DATA_WIDTH-1]; end
          SH_ROR: begin result_d = {w_src_c, w_src_rm[DATA_WIDTH-1:1]}; carry_d = w_src_rm[0]; end
        endcase
      end
    end else begin
      // Register shift uses the full 8-bit amount
      if (w_amt8 == 8'd0) begin
        result_d = w_src_rm;
        carry_d  = w_src_c;
      end else begin
        case (w_type)
          SH_LSL: begin
            if (w_amt8 == 8'd32) begin
              result_d = '0; carry_d = w_src_rm[0];
            end else if (w_amt8 > 8'd32) begin
              result_d = '0; carry_d = 1'b0;
            end
          end
          SH_LSR: begin
            if (w_amt8 == 8'd32) begin
              result_d = '0; carry_d = w_src_rm[DATA_WIDTH-1];
            end else if (w_amt8 > 8'd32) begin
              result_d = '0; carry_d = 1'b0;
            end
          end
          SH_ASR: begin
            if (w_amt8 >= 8'd32) begin
              result_d = {DATA_WIDTH{w_src_rm[DATA_WIDTH-1]}};
              carry_d  = w_src_rm[DATA_WIDTH-1];
            end
          end
          SH_ROR: begin
            // Whole multiples of 32 leave Rm in place but still set carry
            if (w_amt8[AW-1:0] == '0) begin
              result_d = w_src_rm;
              carry_d  = w_src_rm[DATA_WIDTH-1];
            end
          end
        endcase
      end
    end
  end

  // Next-state and handshake outputs
  always_comb begin
    state_d = state_q;
    o_ready = 1'b0;
    o_valid = 1'b0;
    case (state_q)
      ST_IDLE: begin
        o_ready = 1'b1;
        if (i_valid) state_d = w_in_regsh ? ST_RS_WAIT : ST_OUT;
      end
      ST_RS_WAIT: begin
        state_d = ST_OUT;
      end
      ST_OUT: begin
        o_valid = 1'b1;
        o_ready = i_ready;
        if (i_ready) begin
          if (i_valid) state_d = w_in_regsh ? ST_RS_WAIT : ST_OUT;
          else         state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Result register loads on a non-Rs accept or at the end of RS_WAIT
  assign w_load = (w_accept && !w_in_regsh) || w_sel_rs;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= ST_IDLE;
      rm_q      <= '0;
      c_q       <= 1'b0;
      type_q    <= SH_LSL;
      rs_addr_q <= '0;
      result_q  <= '0;
      carry_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (w_accept) begin
        rm_q      <= i_rm_data;
        c_q       <= i_carry;
        type_q    <= shift_type_e'(i_operand2[OP2_TYPE_MSB:OP2_TYPE_LSB]);
        rs_addr_q <= i_operand2[OP2_RS_MSB:OP2_RS_LSB];
      end
      if (w_load) begin
        result_q <= result_d;
        carry_q  <= carry_d;
      end
    end
  end

  // Rs strobe is combinational so the register file sees it in the accept cycle
  assign o_rs_req  = w_accept && w_in_regsh;
  assign o_rs_addr = o_rs_req ? i_operand2[OP2_RS_MSB:OP2_RS_LSB] : rs_addr_q;
  assign o_result  = result_q;
  assign o_carry   = carry_q;

endmodule : shifter_operand
`default_nettype wire

// File: tb/tb_shifter_operand.sv
`default_nettype none
// ============================================================================
// Module      : tb_shifter_operand
// Description : Self-checking bench for shifter_operand: directed vector
//               table, backpressure / back-to-back and reset sequences, and a
//               randomized run against a bit-serial ARM shifter model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_shifter_operand;

  logic        clk = 1'b0;
  logic        i_rst_n;
  logic        i_valid;
  logic        o_ready;
  logic        i_imm;
  logic [11:0] i_operand2;
  logic [31:0] i_rm_data;
  logic        i_carry;
  logic        o_rs_req;
  logic [3:0]  o_rs_addr;
  logic [31:0] i_rs_data;
  logic        o_valid;
  logic        i_ready;
  logic [31:0] o_result;
  logic        o_carry;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  shifter_operand #(.DATA_WIDTH(32)) dut (
    .i_clk      (clk),
    .i_rst_n    (i_rst_n),
    .i_valid    (i_valid),
    .o_ready    (o_ready),
    .i_imm      (i_imm),
    .i_operand2 (i_operand2),
    .i_rm_data  (i_rm_data),
    .i_carry    (i_carry),
    .o_rs_req   (o_rs_req),
    .o_rs_addr  (o_rs_addr),
    .i_rs_data  (i_rs_data),
    .o_valid    (o_valid),
    .i_ready    (i_ready),
    .o_result   (o_result),
    .o_carry    (o_carry)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // ARM shifter model: performs the shift one bit at a time, carrying the
  // last bit out, which naturally covers amounts of 32 and beyond.
  function automatic logic [32:0] model(input logic imm, input logic [11:0] op2,
                                        input logic [31:0] rm, input logic c,
                                        input logic [31:0] rs);
    logic [31:0] r;
    logic        cy;
    logic [1:0]  t;
    int          n;
    cy = c;
    if (imm) begin
      r = {24'h0, op2[7:0]};
      t = 2'b11;
      n = 2 * int'(op2[11:8]);
    end else if (!op2[4]) begin
      r = rm;
      t = op2[6:5];
      n = int'(op2[11:7]);
      if (n == 0) begin
        if (t == 2'b01 || t == 2'b10) n = 32;
        else if (t == 2'b11) return {rm[0], c, rm[31:1]};
      end
    end else begin
      r = rm;
      t = op2[6:5];
      n = int'(rs[7:0]);
    end
    for (int i = 0; i < n; i++) begin
      case (t)
        2'b00: begin cy = r[31]; r = r << 1; end
        2'b01: begin cy = r[0];  r = r >> 1; end
        2'b10: begin cy = r[0];  r = {r[31], r[31:1]}; end
        default: begin cy = r[0]; r = {r[0], r[31:1]}; end
      endcase
    end
    return {cy, r};
  endfunction

  typedef struct {
    string       name;
    logic        imm;
    logic [11:0] op2;
    logic [31:0] rm;
    logic        c;
    logic [31:0] rs;
    logic [31:0] exp_res;
    logic        exp_c;
  } vec_t;

  function automatic vec_t mk(input string n, input logic imm, input logic [11:0] op2,
                              input logic [31:0] rm, input logic c, input logic [31:0] rs,
                              input logic [31:0] er, input logic ec);
    vec_t v;
    v.name = n; v.imm = imm; v.op2 = op2; v.rm = rm; v.c = c; v.rs = rs;
    v.exp_res = er; v.exp_c = ec;
    return v;
  endfunction

  vec_t vecs[14];

  // One request through the full handshake with no stalls
  task automatic run_one(input vec_t v);
    logic is_reg;
    is_reg = !v.imm && v.op2[4];
    @(negedge clk);
    i_valid = 1'b1; i_imm = v.imm; i_operand2 = v.op2;
    i_rm_data = v.rm; i_carry = v.c; i_ready = 1'b0;
    #1;
    chk({v.name, " ready"}, 32'(o_ready), 32'd1);
    chk({v.name, " rs_req"}, 32'(o_rs_req), 32'(is_reg));
    if (is_reg) chk({v.name, " rs_addr"}, 32'(o_rs_addr), 32'(v.op2[11:8]));
    @(negedge clk);
    // Scramble inputs after accept; the captured request must be unaffected
    i_valid = 1'b0; i_imm = ~v.imm; i_operand2 = ~v.op2;
    i_rm_data = ~v.rm; i_carry = ~v.c;
    if (is_reg) begin
      chk({v.name, " wait valid"}, 32'(o_valid), 32'd0);
      i_rs_data = v.rs;
      @(negedge clk);
      i_rs_data = ~v.rs;
    end
    chk({v.name, " valid"}, 32'(o_valid), 32'd1);
    chk({v.name, " result"}, o_result, v.exp_res);
    chk({v.name, " carry"}, 32'(o_carry), 32'(v.exp_c));
    i_ready = 1'b1;
    @(negedge clk);
    chk({v.name, " drained"}, 32'(o_valid), 32'd0);
    i_ready = 1'b0;
  endtask

  logic [32:0] q_exp[$];

  initial begin
    logic        accepted;
    logic        rs_due;
    logic [31:0] rs_next;
    logic [31:0] cur_rs;
    logic        prev_stall;
    logic [31:0] prev_res;
    logic        prev_c;
    logic [32:0] e;
    int          sent;

    i_rst_n = 1'b0; i_valid = 1'b0; i_imm = 1'b0; i_operand2 = '0;
    i_rm_data = '0; i_carry = 1'b0; i_rs_data = '0; i_ready = 1'b0;

    vecs[0]  = mk("imm rot4",   1'b1, 12'h4FF, 32'h00000000, 1'b0, 32'h0,   32'hFF000000, 1'b1);
    vecs[1]  = mk("imm rot0",   1'b1, 12'h012, 32'h00000000, 1'b1, 32'h0,   32'h00000012, 1'b1);
    vecs[2]  = mk("lsr #0",     1'b0, 12'h020, 32'h80000001, 1'b0, 32'h0,   32'h00000000, 1'b1);
    vecs[3]  = mk("asr #0",     1'b0, 12'h040, 32'h80000001, 1'b0, 32'h0,   32'hFFFFFFFF, 1'b1);
    vecs[4]  = mk("rrx",        1'b0, 12'h060, 32'h80000001, 1'b0, 32'h0,   32'h40000000, 1'b1);
    vecs[5]  = mk("lsl #0",     1'b0, 12'h000, 32'h80000001, 1'b0, 32'h0,   32'h80000001, 1'b0);
    vecs[6]  = mk("lsl #4",     1'b0, 12'h200, 32'h80000001, 1'b0, 32'h0,   32'h00000010, 1'b0);
    vecs[7]  = mk("lsr #1",     1'b0, 12'h0A0, 32'h80000001, 1'b0, 32'h0,   32'h40000000, 1'b1);
    vecs[8]  = mk("reg lsl 32", 1'b0, 12'h310, 32'h80000001, 1'b0, 32'd32,  32'h00000000, 1'b1);
    vecs[9]  = mk("reg lsl 33", 1'b0, 12'h310, 32'h80000001, 1'b0, 32'd33,  32'h00000000, 1'b0);
    vecs[10] = mk("reg ror 32", 1'b0, 12'h370, 32'h80000001, 1'b0, 32'h20,  32'h80000001, 1'b1);
    vecs[11] = mk("reg ror 256",1'b0, 12'h370, 32'h80000001, 1'b0, 32'h100, 32'h80000001, 1'b0);
    vecs[12] = mk("reg asr 40", 1'b0, 12'h550, 32'h80000001, 1'b0, 32'd40,  32'hFFFFFFFF, 1'b1);
    vecs[13] = mk("reg lsr 4",  1'b0, 12'h230, 32'h80000001, 1'b0, 32'd4,   32'h08000000, 1'b0);

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    chk("reset valid", 32'(o_valid), 32'd0);
    chk("reset result", o_result, 32'h0);
    chk("reset carry", 32'(o_carry), 32'd0);
    chk("reset rs_req", 32'(o_rs_req), 32'd0);
    chk("reset rs_addr", 32'(o_rs_addr), 32'd0);
    chk("reset ready", 32'(o_ready), 32'd1);
    @(negedge clk);
    i_rst_n = 1'b1;

    for (int i = 0; i < 14; i++) run_one(vecs[i]);

    // Backpressure then back-to-back immediate request
    @(negedge clk);
    i_valid = 1'b1; i_imm = 1'b1; i_operand2 = 12'h4FF; i_carry = 1'b0; i_ready = 1'b0;
    @(negedge clk);
    i_valid = 1'b0; i_operand2 = 12'h0AB; i_carry = 1'b1;
    for (int k = 0; k < 3; k++) begin
      chk("stall valid", 32'(o_valid), 32'd1);
      chk("stall result", o_result, 32'hFF000000);
      chk("stall carry", 32'(o_carry), 32'd1);
      @(negedge clk);
    end
    i_ready = 1'b1; i_valid = 1'b1; i_imm = 1'b1; i_operand2 = 12'h012; i_carry = 1'b1;
    #1;
    chk("b2b ready", 32'(o_ready), 32'd1);
    @(negedge clk);
    i_valid = 1'b0;
    chk("b2b valid", 32'(o_valid), 32'd1);
    chk("b2b result", o_result, 32'h00000012);
    chk("b2b carry", 32'(o_carry), 32'd1);
    @(negedge clk);
    chk("b2b drained", 32'(o_valid), 32'd0);
    i_ready = 1'b0;

    // Reset while waiting for Rs
    @(negedge clk);
    i_valid = 1'b1; i_imm = 1'b0; i_operand2 = 12'h310; i_rm_data = 32'h80000001; i_carry = 1'b0;
    @(negedge clk);
    i_valid = 1'b0;
    #1;
    chk("rswait ready", 32'(o_ready), 32'd0);
    i_rst_n = 1'b0;
    #1;
    chk("rst mid valid", 32'(o_valid), 32'd0);
    chk("rst mid ready", 32'(o_ready), 32'd1);
    chk("rst mid result", o_result, 32'h0);
    @(negedge clk);
    i_rs_data = 32'd32;
    i_rst_n = 1'b1;
    i_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("post rst no output", 32'(o_valid), 32'd0);
    end

    // Randomized regression with stalls and back-to-back traffic
    accepted = 1'b0; rs_due = 1'b0; rs_next = '0; cur_rs = '0;
    prev_stall = 1'b0; prev_res = '0; prev_c = 1'b0; sent = 0;
    for (int cyc = 0; cyc < 20000 && !(sent >= 500 && q_exp.size() == 0); cyc++) begin
      @(negedge clk);
      if (accepted) begin
        i_valid = 1'b0;
        accepted = 1'b0;
      end
      i_ready = ($urandom_range(0, 3) != 0);
      if (rs_due) begin
        i_rs_data = rs_next;
        rs_due = 1'b0;
      end else begin
        i_rs_data = $urandom;
      end
      if (!i_valid) begin
        i_rm_data  = ($urandom_range(0, 3) == 0) ? 32'h80000001 : $urandom;
        i_carry    = 1'($urandom);
        i_operand2 = 12'($urandom);
        i_imm      = 1'($urandom);
        cur_rs     = $urandom;
        if (sent < 500 && $urandom_range(0, 2) != 0) begin
          i_valid = 1'b1;
          case ($urandom_range(0, 2))
            0: i_imm = 1'b1;
            1: begin i_imm = 1'b0; i_operand2[4] = 1'b0; end
            default: begin
              i_imm = 1'b0; i_operand2[4] = 1'b1; i_operand2[7] = 1'b0;
              case ($urandom_range(0, 4))
                0: cur_rs[7:0] = 8'd0;
                1: cur_rs[7:0] = 8'd32;
                2: cur_rs[7:0] = 8'($urandom_range(33, 255));
                3: cur_rs[7:0] = 8'($urandom_range(1, 31));
                default: cur_rs[7:0] = 8'($urandom_range(1, 7) * 32);
              endcase
            end
          endcase
        end
      end
      #1;
      if (prev_stall) begin
        chk("rand hold valid", 32'(o_valid), 32'd1);
        chk("rand hold result", o_result, prev_res);
        chk("rand hold carry", 32'(o_carry), 32'(prev_c));
      end
      if (o_valid && i_ready) begin
        if (q_exp.size() == 0) begin
          chk("rand unexpected output", 32'(o_valid), 32'd0);
        end else begin
          e = q_exp.pop_front();
          chk("rand result", o_result, e[31:0]);
          chk("rand carry", 32'(o_carry), 32'(e[32]));
        end
      end
      prev_stall = o_valid && !i_ready;
      prev_res   = o_result;
      prev_c     = o_carry;
      if (i_valid && o_ready) begin
        q_exp.push_back(model(i_imm, i_operand2, i_rm_data, i_carry, cur_rs));
        chk("rand rs_req", 32'(o_rs_req), 32'(!i_imm && i_operand2[4]));
        if (!i_imm && i_operand2[4]) begin
          chk("rand rs_addr", 32'(o_rs_addr), 32'(i_operand2[11:8]));
          rs_due  = 1'b1;
          rs_next = cur_rs;
        end
        accepted = 1'b1;
        sent++;
      end
    end
    n_checks++;
    if (sent < 500 || q_exp.size() != 0) begin
      n_errors++;
      $display("FAIL rand timeout: sent %0d of 500, %0d results outstanding", sent, q_exp.size());
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule : tb_shifter_operand
`default_nettype wire
